seq_decoder: RTL and testbench

Registered, parametrised N-to-2^N one-hot decoder with enable, valid/ready select handshake and three operating modes: direct (hold), pulse (one-shot) and autonomous scan. It is the successor to the team's combinational 2-to-4 decoder. It sits between control logic and 2^N downstream select/strobe lines, such as row drivers, channel enables or mux selects, and replaces free-running combinational decode with a clean, glitch-free registered output.

---
 rtl/seq_decoder_pkg.sv | 30 +++
 rtl/seq_decoder_scan_step_counter.sv | 43 ++++
 rtl/seq_decoder.sv | 116 +++++++++++
 tb/tb_seq_decoder.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/seq_decoder_pkg.sv
// Shared definitions for seq_decoder: mode codes, FSM state encoding and
// the scan divider width.
package seq_decoder_pkg;

  localparam logic [1:0] MODE_DIRECT = 2'b00;
  localparam logic [1:0] MODE_SCAN   = 2'b01;
  localparam logic [1:0] MODE_PULSE  = 2'b10;
  localparam logic [1:0] MODE_RSVD   = 2'b11;

  // Wide enough for any SCAN_DIV in 1..255.
  localparam int DIV_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DIRECT = 2'd1,
    ST_SCAN   = 2'd2,
    ST_PULSE  = 2'd3
  } state_t;

  // Mode code that keeps an active state alive; IDLE maps to the reserved code.
  function automatic logic [1:0] state_mode(input state_t st);
    case (st)
      ST_DIRECT: return MODE_DIRECT;
      ST_SCAN:   return MODE_SCAN;
      ST_PULSE:  return MODE_PULSE;
      default:   return MODE_RSVD;
    endcase
  endfunction

endpackage

// File: rtl/seq_decoder_scan_step_counter.sv
// Scan divider and index. idx presents the index the output takes after the
// coming edge; wrap flags that this edge takes the index back to 0.
module scan_step_counter
  import seq_decoder_pkg::*;
#(
  parameter int N        = 2,
  parameter int SCAN_DIV = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  output logic [N-1:0] idx,
  output logic         wrap
);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
  localparam logic [N-1:0]     IDX_ONE  = N'(1);
  localparam logic [N-1:0]     IDX_LAST = {N{1'b1}};

  logic [DIV_W-1:0] div_r;
  logic [N-1:0]     idx_r;
  logic             step_s;

  assign step_s = en && (div_r == DIV_LAST);
  assign idx    = step_s ? (idx_r + IDX_ONE) : idx_r;
  assign wrap   = step_s && (idx_r == IDX_LAST);

  // Divider counts dwell cycles; index advances when the dwell completes.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      div_r <= {DIV_W{1'b0}};
      idx_r <= {N{1'b0}};
    end else if (step_s) begin
      div_r <= {DIV_W{1'b0}};
      idx_r <= idx_r + IDX_ONE;
    end else if (en) begin
      div_r <= div_r + DIV_ONE;
    end
  end

endmodule

// File: rtl/seq_decoder.sv
// Registered N-to-2^N one-hot decoder with direct, pulse and scan modes and a
// valid/ready select handshake.
module seq_decoder
  import seq_decoder_pkg::*;
#(
  parameter  int N        = 2,
  parameter  int SCAN_DIV = 4,
  localparam int OUT_W    = 2**N
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic             sel_valid,
  input  logic [N-1:0]     sel,
  output logic             sel_ready,
  output logic [OUT_W-1:0] y,
  output logic             y_valid,
  output logic             scan_wrap
);

  localparam logic [OUT_W-1:0] Y_ZERO  = {OUT_W{1'b0}};
  localparam logic [OUT_W-1:0] Y_FIRST = OUT_W'(1);

  state_t           state_r, state_nxt_s;
  logic [OUT_W-1:0] y_r, y_nxt_s;
  logic             y_valid_r, scan_wrap_r, wrap_nxt_s;
  logic             stay_s, accept_s, scan_run_s;
  logic [N-1:0]     scan_idx_s;
  logic             scan_wrap_s;

  // An active state survives only while enabled and its mode is still selected.
  assign stay_s     = en && (state_r != ST_IDLE) && (mode == state_mode(state_r));
  assign sel_ready  = stay_s && ((state_r == ST_DIRECT) || (state_r == ST_PULSE));
  assign accept_s   = sel_valid && sel_ready;
  assign scan_run_s = stay_s && (state_r == ST_SCAN);

  scan_step_counter #(
    .N        (N),
    .SCAN_DIV (SCAN_DIV)
  ) u_scan (
    .clk  (clk),
    .rst  (rst),
    .clr  (!scan_run_s),
    .en   (scan_run_s),
    .idx  (scan_idx_s),
    .wrap (scan_wrap_s)
  );

  // Next state and next output values; leaving any state zeroes the outputs.
  always_comb begin
    state_nxt_s = state_r;
    y_nxt_s     = Y_ZERO;
    wrap_nxt_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (en) begin
          case (mode)
            MODE_DIRECT: state_nxt_s = ST_DIRECT;
            MODE_SCAN: begin
              state_nxt_s = ST_SCAN;
              y_nxt_s     = Y_FIRST;
            end
            MODE_PULSE:  state_nxt_s = ST_PULSE;
            default:     state_nxt_s = ST_IDLE;
          endcase
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_DIRECT: begin
        if (stay_s) begin
          y_nxt_s = accept_s ? (Y_FIRST << sel) : y_r;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_PULSE: begin
        if (stay_s) begin
          y_nxt_s = accept_s ? (Y_FIRST << sel) : Y_ZERO;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_SCAN: begin
        if (stay_s) begin
          y_nxt_s    = Y_FIRST << scan_idx_s;
          wrap_nxt_s = scan_wrap_s;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // State and output registers; y_valid is derived from the value being loaded.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      y_r         <= Y_ZERO;
      y_valid_r   <= 1'b0;
      scan_wrap_r <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      y_r         <= y_nxt_s;
      y_valid_r   <= |y_nxt_s;
      scan_wrap_r <= wrap_nxt_s;
    end
  end

  assign y         = y_r;
  assign y_valid   = y_valid_r;
  assign scan_wrap = scan_wrap_r;

endmodule

// File: tb/tb_seq_decoder.sv
// Self-checking bench for seq_decoder (N=2, SCAN_DIV=4): behavioural model
// checked every cycle plus hand-computed pins at key points.
module tb_seq_decoder;
  import seq_decoder_pkg::*;

  localparam int N        = 2;
  localparam int SCAN_DIV = 4;
  localparam int OUT_W    = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic [1:0] mode = 2'b00;
  logic       sel_valid = 1'b0;
  logic [1:0] sel = 2'b00;
  logic       sel_ready;
  logic [3:0] y;
  logic       y_valid;
  logic       scan_wrap;

  int n_checks = 0;
  int n_fail   = 0;

  // model: active flag, the mode it is active in, scan time since entry
  bit         m_active = 1'b0;
  logic [1:0] m_mode   = 2'b00;
  int         m_t      = 0;
  logic [3:0] ey       = 4'b0000;
  logic       ew       = 1'b0;

  seq_decoder #(.N(N), .SCAN_DIV(SCAN_DIV)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .mode      (mode),
    .sel_valid (sel_valid),
    .sel       (sel),
    .sel_ready (sel_ready),
    .y         (y),
    .y_valid   (y_valid),
    .scan_wrap (scan_wrap)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic bit model_ready();
    return m_active && en && (mode == m_mode) &&
           ((m_mode == MODE_DIRECT) || (m_mode == MODE_PULSE));
  endfunction

  // Model advances on each edge from the sampled inputs, then outputs are compared.
  always @(posedge clk) begin
    bit acc;
    acc = sel_valid && model_ready();
    ew  = 1'b0;
    if (rst) begin
      m_active = 1'b0;
      ey       = 4'b0000;
    end else if (!m_active) begin
      ey = 4'b0000;
      if (en && (mode != MODE_RSVD)) begin
        m_active = 1'b1;
        m_mode   = mode;
        m_t      = 0;
        if (mode == MODE_SCAN) ey = 4'b0001;
      end
    end else if (!en || (mode != m_mode)) begin
      m_active = 1'b0;
      ey       = 4'b0000;
    end else begin
      case (m_mode)
        MODE_DIRECT: if (acc) ey = 4'b0001 << sel;
        MODE_PULSE:  ey = acc ? (4'b0001 << sel) : 4'b0000;
        default: begin
          m_t = m_t + 1;
          ey  = 4'b0001 << ((m_t / SCAN_DIV) % OUT_W);
          ew  = ((m_t % (OUT_W * SCAN_DIV)) == 0);
        end
      endcase
    end
    #1;
    chk("y", 32'(y), 32'(ey));
    chk("y_valid", 32'(y_valid), 32'(ey != 4'b0000));
    chk("scan_wrap", 32'(scan_wrap), 32'(ew));
  end

  always @(negedge clk) begin
    chk("sel_ready", 32'(sel_ready), 32'(model_ready()));
  end

  // One clock: present inputs, let the edge pass, return 3 time units after it.
  task automatic cyc(input logic e, input logic [1:0] m, input logic v, input logic [1:0] s);
    en = e; mode = m; sel_valid = v; sel = s;
    @(posedge clk); #3;
  endtask

  initial begin
    logic [3:0] dir_exp [4];
    dir_exp[0] = 4'b0001; dir_exp[1] = 4'b0010; dir_exp[2] = 4'b0100; dir_exp[3] = 4'b1000;

    // reset held two cycles with scan requested
    en = 1'b1; mode = MODE_SCAN; rst = 1'b1;
    @(posedge clk); #3;
    chk("pin_rst_y0", 32'(y), 32'h0);
    @(posedge clk); #3;
    chk("pin_rst_y1", 32'(y), 32'h0);
    chk("pin_rst_wrap", 32'(scan_wrap), 32'h0);
    rst = 1'b0;
    cyc(1'b1, MODE_SCAN, 1'b0, 2'd0);
    chk("pin_scan_after_rst", 32'(y), 32'h1);
    cyc(1'b0, MODE_SCAN, 1'b0, 2'd0);
    chk("pin_idle", 32'(y), 32'h0);

    // direct: each select decoded and held
    cyc(1'b1, MODE_DIRECT, 1'b0, 2'd0);
    chk("pin_direct_entry", 32'(y_valid), 32'h0);
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, MODE_DIRECT, 1'b1, 2'(i));
      chk("pin_direct_dec", 32'(y), 32'(dir_exp[i]));
    end
    cyc(1'b1, MODE_DIRECT, 1'b0, 2'd0);
    chk("pin_direct_hold", 32'(y), 32'h8);
    cyc(1'b0, MODE_DIRECT, 1'b1, 2'd1);
    chk("pin_en_drop_accept", 32'(y), 32'h0);

    // mode change from direct (y=1000) to scan
    cyc(1'b1, MODE_DIRECT, 1'b0, 2'd0);
    cyc(1'b1, MODE_DIRECT, 1'b1, 2'd3);
    chk("pin_direct_3", 32'(y), 32'h8);
    cyc(1'b1, MODE_SCAN, 1'b0, 2'd0);
    chk("pin_modechg_gap", 32'(y), 32'h0);
    cyc(1'b1, MODE_SCAN, 1'b0, 2'd0);
    chk("pin_modechg_scan", 32'(y), 32'h1);
    cyc(1'b0, MODE_SCAN, 1'b0, 2'd0);

    // pulse: two back-to-back accepts of sel=10
    cyc(1'b1, MODE_PULSE, 1'b0, 2'd0);
    en = 1'b1; mode = MODE_PULSE; sel_valid = 1'b1; sel = 2'd2; #1;
    chk("pin_pulse_ready", 32'(sel_ready), 32'h1);
    @(posedge clk); #3;
    chk("pin_pulse_1", 32'(y), 32'h4);
    cyc(1'b1, MODE_PULSE, 1'b1, 2'd2);
    chk("pin_pulse_2", 32'(y), 32'h4);
    cyc(1'b1, MODE_PULSE, 1'b0, 2'd0);
    chk("pin_pulse_end", 32'(y), 32'h0);
    cyc(1'b0, MODE_PULSE, 1'b0, 2'd0);

    // scan for 40 cycles, with an ignored select offered mid-run
    for (int i = 1; i <= 40; i++) begin
      en = 1'b1; mode = MODE_SCAN; sel_valid = (i >= 20 && i <= 24); sel = 2'd3; #1;
      if (i >= 20 && i <= 24) chk("pin_scan_not_ready", 32'(sel_ready), 32'h0);
      @(posedge clk); #3;
      if (i == 5)  chk("pin_scan_c5", 32'(y), 32'h2);
      if (i == 16) chk("pin_scan_c16", 32'({scan_wrap, y}), 32'h08);
      if (i == 17) chk("pin_scan_c17", 32'({scan_wrap, y}), 32'h11);
      if (i == 24) chk("pin_scan_c24", 32'(y), 32'h2);
      if (i == 33) chk("pin_scan_c33", 32'({scan_wrap, y}), 32'h11);
    end

    // idle drops a select
    cyc(1'b0, MODE_SCAN, 1'b1, 2'd3);
    cyc(1'b0, MODE_DIRECT, 1'b1, 2'd2);
    chk("pin_idle_drop", 32'(y), 32'h0);

    // reset mid-operation has priority
    cyc(1'b1, MODE_DIRECT, 1'b0, 2'd0);
    cyc(1'b1, MODE_DIRECT, 1'b1, 2'd1);
    chk("pin_pre_rst", 32'(y), 32'h2);
    rst = 1'b1;
    cyc(1'b1, MODE_DIRECT, 1'b1, 2'd2);
    chk("pin_mid_rst", 32'({y_valid, y}), 32'h00);
    rst = 1'b0;
    cyc(1'b0, MODE_DIRECT, 1'b0, 2'd0);
    cyc(1'b0, MODE_DIRECT, 1'b0, 2'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
